// File: rtl/aes_pkg.sv
// Shared AES-128 decipher definitions: sizes, inverse S-box, GF(2^8) multipliers and FSM states.
package aes_pkg;

  localparam int unsigned NR          = 10;
  localparam int unsigned BLOCO_W     = 128;
  localparam int unsigned CHAVE_EXP_W = NR * BLOCO_W;

  typedef enum logic [1:0] {OCIOSO, RODADA, SAIDA} estado_t;

  // Entry 0x00 sits in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  // Byte i of a state, byte 0 in the top bits.
  function automatic logic [7:0] byte_de(input logic [BLOCO_W-1:0] v, input int i);
    return v[BLOCO_W - 1 - 8 * i -: 8];
  endfunction

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/miolo_decifra_bloco.sv
// One AES-128 inverse round: InvShiftRows, InvSubBytes, AddRoundKey k[rodada], then
// InvMixColumns unless this is the final round (rodada == 0).
module miolo_decifra_bloco
  import aes_pkg::*;
(
  input  logic [BLOCO_W-1:0]     bloco,
  input  logic [CHAVE_EXP_W-1:0] chaveExpandida,
  input  logic [BLOCO_W-1:0]     chave,
  input  logic [3:0]             rodada,
  output logic [BLOCO_W-1:0]     saida
);

  logic [7:0]         sub [16];
  logic [3:0]         idx_chave;
  logic [BLOCO_W-1:0] chave_rodada;
  logic [BLOCO_W-1:0] apos_chave;

  // Row r is rotated right by r while substituting.
  always_comb begin
    sub = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[r + 4 * c] = inv_sbox(byte_de(bloco, r + 4 * ((c + 4 - r) % 4)));
      end
    end
  end

  // Round key 0 is the original key; k1..k10 live in the expanded key.
  assign idx_chave = (rodada == 4'd0 || rodada > 4'(NR)) ? 4'd0 : rodada - 4'd1;

  always_comb begin
    chave_rodada = chaveExpandida[BLOCO_W * idx_chave +: BLOCO_W];
    if (rodada == 4'd0) begin
      chave_rodada = chave;
    end
  end

  always_comb begin
    apos_chave = '0;
    for (int i = 0; i < 16; i++) begin
      apos_chave[BLOCO_W - 1 - 8 * i -: 8] = sub[i] ^ byte_de(chave_rodada, i);
    end
  end

  always_comb begin
    saida = apos_chave;
    if (rodada != 4'd0) begin
      for (int c = 0; c < 4; c++) begin
        saida[127 - 32 * c -: 8] = gf_mul0e(byte_de(apos_chave, 4 * c))
                                 ^ gf_mul0b(byte_de(apos_chave, 4 * c + 1))
                                 ^ gf_mul0d(byte_de(apos_chave, 4 * c + 2))
                                 ^ gf_mul09(byte_de(apos_chave, 4 * c + 3));
        saida[119 - 32 * c -: 8] = gf_mul09(byte_de(apos_chave, 4 * c))
                                 ^ gf_mul0e(byte_de(apos_chave, 4 * c + 1))
                                 ^ gf_mul0b(byte_de(apos_chave, 4 * c + 2))
                                 ^ gf_mul0d(byte_de(apos_chave, 4 * c + 3));
        saida[111 - 32 * c -: 8] = gf_mul0d(byte_de(apos_chave, 4 * c))
                                 ^ gf_mul09(byte_de(apos_chave, 4 * c + 1))
                                 ^ gf_mul0e(byte_de(apos_chave, 4 * c + 2))
                                 ^ gf_mul0b(byte_de(apos_chave, 4 * c + 3));
        saida[103 - 32 * c -: 8] = gf_mul0b(byte_de(apos_chave, 4 * c))
                                 ^ gf_mul0d(byte_de(apos_chave, 4 * c + 1))
                                 ^ gf_mul09(byte_de(apos_chave, 4 * c + 2))
                                 ^ gf_mul0e(byte_de(apos_chave, 4 * c + 3));
      end
    end
  end

endmodule

// File: rtl/decifra_bloco_iterativo.sv
// Iterative AES-128 block decipher, one inverse round per clock with valid/ready on both sides.
// Defining DECIFRA_DEBUG_EN adds the rodada_atual and ocupado observation ports.
module decifra_bloco_iterativo
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLOCO_W-1:0]     bloco,
  input  logic [BLOCO_W-1:0]     chave,
  input  logic [CHAVE_EXP_W-1:0] chaveExpandida,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef DECIFRA_DEBUG_EN
  output logic [3:0]             rodada_atual,
  output logic                   ocupado,
`endif
  output logic [BLOCO_W-1:0]     saida
);

  localparam logic [3:0] RODADA_INI = 4'(NR - 1);

  estado_t            estado_q, estado_d;
  logic [BLOCO_W-1:0] estado_bloco_q;
  logic [BLOCO_W-1:0] saida_q;
  logic [BLOCO_W-1:0] resultado_rodada;
  logic [3:0]         rodada_q;

  miolo_decifra_bloco u_miolo (
    .bloco          (estado_bloco_q),
    .chaveExpandida (chaveExpandida),
    .chave          (chave),
    .rodada         (rodada_q),
    .saida          (resultado_rodada)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:  if (in_valid)            estado_d = RODADA;
      RODADA:  if (rodada_q == 4'd0)    estado_d = SAIDA;
      SAIDA:   if (out_ready)           estado_d = OCIOSO;
      default:                          estado_d = OCIOSO;
    endcase
  end

  // Keys are not latched: the caller holds them until the result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_bloco_q <= '0;
      rodada_q       <= '0;
      saida_q        <= '0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (in_valid) begin
            estado_bloco_q <= bloco ^ chaveExpandida[CHAVE_EXP_W-1 -: BLOCO_W];
            rodada_q       <= RODADA_INI;
          end
        end
        RODADA: begin
          estado_bloco_q <= resultado_rodada;
          if (rodada_q == 4'd0) begin
            saida_q <= resultado_rodada;
          end else begin
            rodada_q <= rodada_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (estado_q == OCIOSO);
    out_valid = (estado_q == SAIDA);
    saida     = saida_q;
`ifdef DECIFRA_DEBUG_EN
    rodada_atual = (estado_q == RODADA) ? rodada_q : 4'hF;
    ocupado      = (estado_q != OCIOSO);
`endif
  end

endmodule

// File: tb/tb_decifra_bloco_iterativo.sv
// Scoreboard bench for decifra_bloco_iterativo using the FIPS-197 AES-128 vectors.
module tb_decifra_bloco_iterativo;

  localparam logic [127:0] CHAVE_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [1279:0] EXP_A = {
    128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe
  };
  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;

  localparam logic [127:0] CHAVE_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [1279:0] EXP_B = {
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
    128'head27321b58dbad2312bf5607f8d292f, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hf2c295f27a96b9435935807a7359f67f, 128'ha0fafe1788542cb123a339392a6c7605
  };
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [127:0]  bloco = '0;
  logic [127:0]  chave = '0;
  logic [1279:0] chaveExpandida = '0;
  logic [127:0]  saida;
`ifdef DECIFRA_DEBUG_EN
  logic [3:0]    rodada_atual;
  logic          ocupado;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [127:0]  exp_q [$];
  int unsigned   acc_q [$];
  int unsigned   rise_q [$];
  int unsigned   cyc = 0;
  int unsigned   n_acc = 0;
  logic          ov_prev = 1'b0;

  decifra_bloco_iterativo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .bloco          (bloco),
    .chave          (chave),
    .chaveExpandida (chaveExpandida),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
`ifdef DECIFRA_DEBUG_EN
    .rodada_atual   (rodada_atual),
    .ocupado        (ocupado),
`endif
    .saida          (saida)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check1(input string nm, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic falha(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a block and return just after the accepting edge.
  task automatic envia(input logic [127:0] ct, input logic [127:0] k, input logic [1279:0] ke,
                       input logic [127:0] pt, input bit espera);
    bloco = ct;
    chave = k;
    chaveExpandida = ke;
    in_valid = 1'b1;
    if (espera) exp_q.push_back(pt);
    for (int i = 0; i < 40 && !in_ready; i++) tick(1);
    if (!in_ready) falha("accept timeout");
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drena();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
    if (exp_q.size() != 0) begin
      falha("result timeout");
      exp_q.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: latency on each rising out_valid, data on each output handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      acc_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          falha("out_valid without accepted block");
        end else begin
          check_int("latency", int'(cyc - acc_q.pop_front()), 10);
          rise_q.push_back(cyc);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) falha("unexpected output handshake");
        else check("saida", saida, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;

    #2 rst_n = 1'b0;
    #1;
    check1("reset in_ready", in_ready, 1'b1);
    check1("reset out_valid", out_valid, 1'b0);
    check("reset saida", saida, 128'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    check1("idle in_ready", in_ready, 1'b1);
    check1("idle out_valid", out_valid, 1'b0);

    out_ready = 1'b1;
    envia(CT_A, CHAVE_A, EXP_A, PT_A, 1'b1);
    drena();
    envia(CT_B, CHAVE_B, EXP_B, PT_B, 1'b1);
    drena();

    // Backpressure: result held, second block ignored.
    out_ready = 1'b0;
    envia(CT_A, CHAVE_A, EXP_A, PT_A, 1'b1);
    for (int i = 0; i < 30 && !out_valid; i++) tick(1);
    if (!out_valid) falha("out_valid timeout under backpressure");
    bloco = CT_B;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check1("held out_valid", out_valid, 1'b1);
      check("held saida", saida, PT_A);
      check1("busy in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check1("drained out_valid", out_valid, 1'b0);
    check1("drained in_ready", in_ready, 1'b1);
    tick(15);

    // Reset in the middle of a block.
    envia(CT_A, CHAVE_A, EXP_A, PT_A, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #1;
    check1("midreset in_ready", in_ready, 1'b1);
    check1("midreset out_valid", out_valid, 1'b0);
    check("midreset saida", saida, 128'h0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check1("aborted block silent", out_valid, 1'b0);
    end
    envia(CT_B, CHAVE_B, EXP_B, PT_B, 1'b1);
    drena();

    // Back-to-back with out_ready high.
    rise_q.delete();
    base = n_acc;
    repeat (3) exp_q.push_back(PT_A);
    bloco = CT_A;
    chave = CHAVE_A;
    chaveExpandida = EXP_A;
    in_valid = 1'b1;
    for (int i = 0; i < 80 && n_acc < base + 3; i++) tick(1);
    in_valid = 1'b0;
    if (n_acc < base + 3) falha("back-to-back accept timeout");
    drena();
    tick(3);
    if (rise_q.size() == 3) begin
      check_int("spacing 1-2", int'(rise_q[1] - rise_q[0]), 12);
      check_int("spacing 2-3", int'(rise_q[2] - rise_q[1]), 12);
    end else begin
      falha("back-to-back result count");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decifra_bloco_iterativo.md
Name: decifra_bloco_iterativo

Overview:
- Iterative AES-128 block decipher: one inverse round per clock, ten inverse rounds per 128-bit block.
- Receives ciphertext plus the original key and the expanded key from the existing key-expansion block; returns plaintext.
- This is the decrypt-side counterpart of the encrypt round datapath.
- Sits between the block-level decrypt controller and the output buffer, with valid/ready handshakes on both sides.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, not meant to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext and keys present.
- in_ready  out  1  block can accept a new ciphertext.
- bloco  in  128  ciphertext, byte 0 at bits [127:120].
- chave  in  128  original key, used as round key 0.
- chaveExpandida  in  1280  round key r (1..10) at bits [128*r-1 : 128*(r-1)].
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- saida  out  128  plaintext, same byte order as bloco.

Behaviour:
- Reset (async assert, sync release): estado=OCIOSO, in_ready=1, out_valid=0, saida=0, internal state and round counter=0.
- FSM states:
  - OCIOSO: in_ready=1. On in_valid&in_ready: state register <= bloco ^ k10, rodada <= 9, go to RODADA.
  - RODADA: each edge applies InvShiftRows, then InvSubBytes, then AddRoundKey k[rodada], then InvMixColumns (InvMixColumns only when rodada != 0); rodada decrements.
    - After rodada==0: saida <= result, out_valid <= 1, go to SAIDA.
  - SAIDA: out_valid=1 and saida stable until out_valid&out_ready; then out_valid <= 0, go to OCIOSO.
- Latency: out_valid rises exactly 10 clock edges after the accepting edge.
- Throughput: one block per 12 cycles when out_ready is tied high.
- in_ready=0 in RODADA and SAIDA. No new block is accepted in the cycle the result drains; OCIOSO follows.
- Caller contract: chave and chaveExpandida are held stable from the accepting edge until out_valid. They are not latched.
- in_valid while busy is ignored; no loss of the in-flight block.
- out_ready held low: result held indefinitely, no overwrite.
- rst_n asserted mid-round: in-flight block discarded, all outputs return to reset values immediately.
- All arithmetic is GF(2^8) with polynomial 0x11B; XORs are 128-bit wide; no carries.

Optional Feature:
- Macro: DECIFRA_DEBUG_EN.
- Defined:
  - adds output port rodada_atual (4 bits): current rodada in RODADA, 4'hF otherwise.
  - adds output port ocupado (1 bit): high in RODADA or SAIDA.
- Undefined: neither port exists. Datapath and timing are identical either way.

Decomposition:
- Shared package aes_pkg holds:
  - constants NR=10, BLOCO_W=128, CHAVE_EXP_W=1280;
  - inverse S-box table;
  - GF multiply-by-{09,0B,0D,0E} functions;
  - FSM state typedef (OCIOSO, RODADA, SAIDA).
- One combinational sub-module, miolo_decifra_bloco:
  - inputs: bloco, chaveExpandida, chave, rodada; output: saida;
  - implements one inverse round as defined above;
  - instantiated once in the iterative loop.

Test Plan:
- Reset: rst_n=0 then 1 -> in_ready=1, out_valid=0, saida=0.
- FIPS-197 vector:
  - stimulus: chave=000102030405060708090a0b0c0d0e0f with its expanded key, bloco=69c4e0d86a7b0430d8cdb78070b4c55a;
  - response: out_valid 10 edges after accept, saida=00112233445566778899aabbccddeeff.
- Sub-module inverse round:
  - stimulus: chave=53414548454253454e4f53494841414e with expanded key, rodada=4, bloco=6024c5dfc452a760b995af4cbdbb8aa2;
  - response: saida=2aba85402e36488d8a23ade2c79f3541.
- Backpressure:
  - stimulus: out_ready=0 for 20 cycles after out_valid;
  - response: saida constant, in_ready=0, second in_valid ignored; out_ready=1 -> out_valid drops next edge, in_ready=1.
- Mid-operation reset: rst_n pulsed low at round 5 -> out_valid never asserts for that block; next block decrypts correctly.
- Back-to-back: out_ready tied high, three FIPS blocks presented continuously -> three correct results, 12 cycles apart.
